// File: rtl/aclock_setter_pkg.sv
// Shared types and constants for the aclock time/alarm setter front end.
package aclock_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    E_H1   = 3'd1,
    E_H0   = 3'd2,
    E_M1   = 3'd3,
    E_M0   = 3'd4,
    COMMIT = 3'd5
  } state_t;

  localparam logic [1:0] DIG_H1 = 2'd0;
  localparam logic [1:0] DIG_H0 = 2'd1;
  localparam logic [1:0] DIG_M1 = 2'd2;
  localparam logic [1:0] DIG_M0 = 2'd3;

  localparam logic [3:0] H1_MAX    = 4'd2;
  localparam logic [3:0] H0_MAX    = 4'd9;
  localparam logic [3:0] H0_MAX_20 = 4'd3;
  localparam logic [3:0] M1_MAX    = 4'd5;
  localparam logic [3:0] M0_MAX    = 4'd9;

  // BCD increment with wrap to zero; out-of-range values also wrap.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/aclock_setter_if.sv
// Digit bus between the setter and aclock: current time in, edited digits and load strobes out.
interface aclock_setter_if;
  logic [1:0] H_cur1;
  logic [3:0] H_cur0;
  logic [3:0] M_cur1;
  logic [3:0] M_cur0;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;

  modport master (
    input  H_cur1, H_cur0, M_cur1, M_cur0,
    output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm
  );

  modport slave (
    output H_cur1, H_cur0, M_cur1, M_cur0,
    input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm
  );
endinterface

// File: rtl/aclock_setter_btn_pulse.sv
// Button rising-edge detector with optional hold-to-repeat; clear blocks repeat until release.
module btn_pulse #(
  parameter bit          REPEAT_EN    = 1'b0,
  parameter int unsigned REPEAT_DELAY = 10,
  parameter int unsigned REPEAT_RATE  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clear,
  output logic pulse_c
);

  localparam int unsigned CNT_W = 16;

  logic             q;
  logic             q_d;
  logic             blocked;
  logic             rep;
  logic [CNT_W-1:0] cnt;
  logic             edge_c;
  logic             held_c;
  logic             fire_c;
  logic [CNT_W-1:0] limit_c;

  assign edge_c  = q & ~q_d;
  assign held_c  = q & q_d & ~blocked;
  assign limit_c = rep ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY);
  assign fire_c  = REPEAT_EN & held_c & (cnt == limit_c);
  assign pulse_c = edge_c | fire_c;

  // cnt holds cycles held since the press (or since the last repeat)
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= 1'b0;
      q_d     <= 1'b0;
      blocked <= 1'b0;
      rep     <= 1'b0;
      cnt     <= '0;
    end else begin
      q   <= btn;
      q_d <= q;
      if (!q)        blocked <= 1'b0;
      else if (clear) blocked <= 1'b1;
      if (clear || !q) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (edge_c) begin
        cnt <= CNT_W'(1);
        rep <= 1'b0;
      end else if (held_c) begin
        if (cnt == limit_c) begin
          cnt <= CNT_W'(1);
          rep <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/aclock_setter.sv
// Button-driven time/alarm editor producing BCD digits and one-cycle load strobes for aclock.
module aclock_setter
  import aclock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 10,
  parameter int unsigned REPEAT_RATE  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_mode,
  input  logic                  btn_next,
  input  logic                  btn_inc,
  input  logic                  sel_alarm,
  output logic                  editing,
  output logic [1:0]            edit_digit,
  aclock_setter_if.master       bus
);

  state_t     state, state_n;
  logic [1:0] h1_q, h1_n;
  logic [3:0] h0_q, h0_n, m1_q, m1_n, m0_q, m0_n;
  logic       tgt_q, tgt_n;
  logic       ld_time_q, ld_alarm_q;
  logic       editing_n;
  logic [1:0] edit_digit_n;
  logic       mode_p_c, next_p_c, inc_p_c;
  logic       mode_ev_c, next_ev_c, inc_ev_c;
  logic       state_chg_c;

  btn_pulse #(.REPEAT_EN(1'b0)) u_mode (
    .clk(clk), .reset(reset), .btn(btn_mode), .clear(state_chg_c), .pulse_c(mode_p_c));
  btn_pulse #(.REPEAT_EN(1'b0)) u_next (
    .clk(clk), .reset(reset), .btn(btn_next), .clear(state_chg_c), .pulse_c(next_p_c));
  btn_pulse #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_inc (
    .clk(clk), .reset(reset), .btn(btn_inc), .clear(state_chg_c), .pulse_c(inc_p_c));

  assign mode_ev_c   = mode_p_c;
  assign next_ev_c   = next_p_c & ~mode_p_c;
  assign inc_ev_c    = inc_p_c & ~mode_p_c & ~next_p_c;
  assign state_chg_c = (state_n != state);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      h1_q       <= '0;
      h0_q       <= '0;
      m1_q       <= '0;
      m0_q       <= '0;
      tgt_q      <= 1'b0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      editing    <= 1'b0;
      edit_digit <= '0;
    end else begin
      state      <= state_n;
      h1_q       <= h1_n;
      h0_q       <= h0_n;
      m1_q       <= m1_n;
      m0_q       <= m0_n;
      tgt_q      <= tgt_n;
      ld_time_q  <= (state_n == COMMIT) & ~tgt_q;
      ld_alarm_q <= (state_n == COMMIT) & tgt_q;
      editing    <= editing_n;
      edit_digit <= edit_digit_n;
    end
  end

  always_comb begin
    state_n      = state;
    h1_n         = h1_q;
    h0_n         = h0_q;
    m1_n         = m1_q;
    m0_n         = m0_q;
    tgt_n        = tgt_q;
    unique case (state)
      IDLE: if (mode_ev_c) begin
        state_n = E_H1;
        h1_n    = bus.H_cur1;
        h0_n    = bus.H_cur0;
        m1_n    = bus.M_cur1;
        m0_n    = bus.M_cur0;
        tgt_n   = sel_alarm;
      end
      E_H1: begin
        if (mode_ev_c)      state_n = IDLE;
        else if (next_ev_c) state_n = E_H0;
        else if (inc_ev_c) begin
          h1_n = 2'(bcd_inc(4'(h1_q), H1_MAX));
          // 2x hours cap at 23: clamp an out-of-range units digit immediately
          if (h1_n == 2'(H1_MAX) && h0_q > H0_MAX_20) h0_n = H0_MAX_20;
        end
      end
      E_H0: begin
        if (mode_ev_c)      state_n = IDLE;
        else if (next_ev_c) state_n = E_M1;
        else if (inc_ev_c)
          h0_n = bcd_inc(h0_q, (h1_q == 2'(H1_MAX)) ? H0_MAX_20 : H0_MAX);
      end
      E_M1: begin
        if (mode_ev_c)      state_n = IDLE;
        else if (next_ev_c) state_n = E_M0;
        else if (inc_ev_c)  m1_n = bcd_inc(m1_q, M1_MAX);
      end
      E_M0: begin
        if (mode_ev_c)      state_n = IDLE;
        else if (next_ev_c) state_n = COMMIT;
        else if (inc_ev_c)  m0_n = bcd_inc(m0_q, M0_MAX);
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    editing_n    = (state_n != IDLE);
    edit_digit_n = DIG_H1;
    unique case (state_n)
      E_H0:         edit_digit_n = DIG_H0;
      E_M1:         edit_digit_n = DIG_M1;
      E_M0, COMMIT: edit_digit_n = DIG_M0;
      default:      edit_digit_n = DIG_H1;
    endcase
  end

  assign bus.H_in1    = h1_q;
  assign bus.H_in0    = h0_q;
  assign bus.M_in1    = m1_q;
  assign bus.M_in0    = m0_q;
  assign bus.LD_time  = ld_time_q;
  assign bus.LD_alarm = ld_alarm_q;

endmodule

// File: tb/tb_aclock_setter.sv
// Directed bench for aclock_setter: entry, increment rules, auto-repeat, cancel and reset cases.
module tb_aclock_setter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sel_alarm = 1'b0;
  logic       editing;
  logic [1:0] edit_digit;
  int         total = 0;
  int         bad = 0;

  aclock_setter_if bus();

  aclock_setter #(.REPEAT_DELAY(10), .REPEAT_RATE(3)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_next(btn_next),
    .btn_inc(btn_inc), .sel_alarm(sel_alarm), .editing(editing),
    .edit_digit(edit_digit), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press for one cycle and wait until the resulting event shows on the outputs.
  task automatic press(input int which);
    if (which == 0) btn_mode = 1'b1;
    if (which == 1) btn_next = 1'b1;
    if (which == 2) btn_inc  = 1'b1;
    tick();
    btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    tick();
  endtask

  task automatic set_cur(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                         input logic [3:0] m0);
    bus.H_cur1 = h1; bus.H_cur0 = h0; bus.M_cur1 = m1; bus.M_cur0 = m0;
  endtask

  task automatic check_time(input string tag, input logic [1:0] h1, input logic [3:0] h0,
                            input logic [3:0] m1, input logic [3:0] m0);
    check(tag, 32'({bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0}), 32'({h1, h0, m1, m0}));
  endtask

  localparam int MODE = 0, NEXT = 1, INC = 2;

  initial begin
    set_cur(2'd1, 4'd1, 4'd2, 4'd6);
    tick(); tick();
    reset = 1'b0;
    check_time("rst_digits", 2'd0, 4'd0, 4'd0, 4'd0);
    check("rst_strobes", 32'({bus.LD_time, bus.LD_alarm, editing, edit_digit}), 32'd0);

    // time commit of unchanged 11:26
    press(MODE);
    check("enter_editing", 32'({editing, edit_digit}), 32'b100);
    check_time("enter_load", 2'd1, 4'd1, 4'd2, 4'd6);
    press(NEXT); press(NEXT); press(NEXT);
    check("at_m0", 32'(edit_digit), 32'd3);
    press(NEXT);
    check("commit_strobe", 32'({bus.LD_time, bus.LD_alarm, editing}), 32'b101);
    check_time("commit_digits", 2'd1, 4'd1, 4'd2, 4'd6);
    tick();
    check("after_commit", 32'({bus.LD_time, bus.LD_alarm, editing}), 32'b000);

    // alarm commit 10:20 -> 10:30
    sel_alarm = 1'b1;
    set_cur(2'd1, 4'd0, 4'd2, 4'd0);
    press(MODE);
    sel_alarm = 1'b0;
    press(NEXT); press(NEXT);
    check("alarm_at_m1", 32'(edit_digit), 32'd2);
    press(INC);
    check_time("alarm_inc_m1", 2'd1, 4'd0, 4'd3, 4'd0);
    press(NEXT); press(NEXT);
    check("alarm_strobe", 32'({bus.LD_time, bus.LD_alarm}), 32'b01);
    check_time("alarm_digits", 2'd1, 4'd0, 4'd3, 4'd0);
    tick();
    check("alarm_after", 32'({bus.LD_time, bus.LD_alarm, editing}), 32'b000);

    // hour clamping and wraps from 19:00
    set_cur(2'd1, 4'd9, 4'd0, 4'd0);
    press(MODE);
    press(INC);
    check_time("h1_clamp", 2'd2, 4'd3, 4'd0, 4'd0);
    press(NEXT);
    press(INC);
    check_time("h0_wrap_20", 2'd2, 4'd0, 4'd0, 4'd0);
    press(NEXT);
    for (int i = 0; i < 5; i++) press(INC);
    check_time("m1_five", 2'd2, 4'd0, 4'd5, 4'd0);
    press(INC);
    check_time("m1_wrap", 2'd2, 4'd0, 4'd0, 4'd0);
    press(NEXT);

    // auto-repeat on M0: increments at held cycles 1, 11, 14, 17, 20
    btn_inc = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    check("rep_before_delay", 32'(bus.M_in0), 32'd1);
    tick();
    check("rep_first_repeat", 32'(bus.M_in0), 32'd2);
    for (int i = 0; i < 8; i++) tick();
    btn_inc = 1'b0;
    tick();
    check("rep_total", 32'(bus.M_in0), 32'd5);
    tick();
    check("rep_released", 32'(bus.M_in0), 32'd5);

    // cancel keeps digits; re-entry reloads; mode+next together cancels
    press(MODE);
    check("cancel_idle", 32'({editing, bus.LD_time, bus.LD_alarm}), 32'b000);
    check_time("cancel_keep", 2'd2, 4'd0, 4'd0, 4'd5);
    press(MODE);
    check_time("reentry_load", 2'd1, 4'd9, 4'd0, 4'd0);
    press(NEXT);
    check("at_h0", 32'(edit_digit), 32'd1);
    btn_mode = 1'b1; btn_next = 1'b1;
    tick();
    btn_mode = 1'b0; btn_next = 1'b0;
    tick();
    check("both_cancel", 32'({editing, bus.LD_time, bus.LD_alarm}), 32'b000);
    tick();
    check("both_no_strobe", 32'({editing, bus.LD_time, bus.LD_alarm}), 32'b000);

    // reset on the commit cycle suppresses the strobe
    set_cur(2'd0, 4'd8, 4'd4, 4'd5);
    press(MODE); press(NEXT); press(NEXT); press(NEXT);
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_commit_out", 32'({bus.LD_time, bus.LD_alarm, editing, edit_digit}), 32'd0);
    check_time("rst_commit_digits", 2'd0, 4'd0, 4'd0, 4'd0);
    tick();
    check("rst_commit_after", 32'({bus.LD_time, bus.LD_alarm, editing}), 32'd0);

    // inc/next ignored in IDLE, then mode reloads 08:45
    press(INC); press(NEXT);
    check("idle_ignore", 32'({editing, bus.LD_time, bus.LD_alarm}), 32'd0);
    check_time("idle_digits", 2'd0, 4'd0, 4'd0, 4'd0);
    press(MODE);
    check_time("idle_reload", 2'd0, 4'd8, 4'd4, 4'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aclock_setter.md
# aclock_setter

Button-driven time/alarm entry front end for `aclock`. It turns three debounced push-buttons plus a target switch into the digit buses `H_in1/H_in0/M_in1/M_in0` and a one-cycle `LD_time` or `LD_alarm` strobe, which drive the matching `aclock` load inputs. Editing starts from the clock's current time, which is fed back from `aclock`'s outputs. Runs on the same `clk` as `aclock` (nominally 10 Hz).

## Interface
Parameters:
- `REPEAT_DELAY`, default 10: cycles `btn_inc` must be held before auto-repeat starts.
- `REPEAT_RATE`, default 3: cycles between auto-repeat increments.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high.
- `btn_mode` in 1: enter edit, or cancel edit. Debounced level, synchronous to `clk`.
- `btn_next` in 1: advance to the next digit, or commit on the last digit.
- `btn_inc` in 1: increment the selected digit.
- `sel_alarm` in 1: edit target (0 = time, 1 = alarm). Sampled on edit entry.
- `H_cur1` in 2, `H_cur0` in 4, `M_cur1` in 4, `M_cur0` in 4: current BCD time from `aclock`.
- `H_in1` out 2, `H_in0` out 4, `M_in1` out 4, `M_in0` out 4: registered BCD digits being edited, driven to `aclock`.
- `LD_time` out 1, `LD_alarm` out 1: one-cycle load strobes.
- `editing` out 1: high in any edit state.
- `edit_digit` out 2: selected digit (0 = H1, 1 = H0, 2 = M1, 3 = M0). Valid while `editing` is high.

## Operation
- Rising edges are detected on all three buttons: input high this cycle, low last cycle.
- Event priority within a cycle: mode > next > inc. Only the highest-priority event acts; the others are dropped.
- FSM states:
  - IDLE.
  - E_H1, E_H0, E_M1, E_M0.
  - COMMIT.
- IDLE + mode edge → E_H1. On entry, load digits from `H_cur*`/`M_cur*` and latch `sel_alarm` into `tgt`.
- E_x + next edge → next digit. E_M0 + next edge → COMMIT.
- Any E_x + mode edge → IDLE (cancel). No strobe. Digits keep their last edited values.
- COMMIT: assert `LD_time` if `tgt`=0, else `LD_alarm`, for exactly one cycle, then → IDLE.
- In IDLE, inc and next edges are ignored.
- Increment rules (BCD, wrap to 0):
  - H1: 0→1→2→0. If H1 becomes 2 while H0 > 3, H0 is forced to 3 in the same cycle.
  - H0: wraps after 9, or after 3 when H1 = 2.
  - M1: wraps after 5.
  - M0: wraps after 9.
- Auto-repeat (inc only):
  - First increment on the rising edge.
  - While still held, one more increment after `REPEAT_DELAY` cycles, then one every `REPEAT_RATE` cycles.
  - Release resets the repeat counter.
  - A state change (next/mode) also resets the counter; a held inc produces no increment until it is released and pressed again.
- Digit registers hold their value after commit or cancel; `aclock` ignores them without a strobe.
- `sel_alarm` changes during edit are ignored.

## Timing
- Reset values: all digit outputs 0; `LD_time`, `LD_alarm`, `editing` = 0; `edit_digit` = 0; state IDLE; edge registers cleared. A button held through reset therefore produces an edge on the first cycle after reset.
- Latency: an event sampled at edge n is visible on outputs after edge n+1 (1 cycle).
  - Mode press → `editing`=1, `edit_digit`=0, digits = current time.
  - Inc press → new digit value.
  - Next on E_M0 → strobe high for cycle n+1, low and `editing`=0 from n+2.
- The strobe is never high in the same cycle as a digit change. Digits are stable for at least 1 cycle before and during the strobe.
- `LD_time` and `LD_alarm` are never high together.
- Reset mid-edit or in COMMIT: IDLE next cycle, no strobe.

## Structure
- Package `aclock_pkg`:
  - state enum.
  - digit-index constants.
  - max constants: H1_MAX=2, H0_MAX=9, H0_MAX_20=3, M1_MAX=5, M0_MAX=9.
- Sub-module `btn_pulse`: edge detect with optional auto-repeat (parameters `REPEAT_EN`, `REPEAT_DELAY`, `REPEAT_RATE`).
  - One instance per button; repeat is enabled only for inc.

## Test plan
- Reset, cur=11:26, `sel_alarm`=0, mode, next ×4 → `LD_time` high exactly 1 cycle with outputs 11:26; `editing` low 1 cycle later.
- `sel_alarm`=1, cur=10:20. Mode, next ×2 (to M1), inc, next, next → `LD_alarm` pulse with 10:30; `LD_time` stays 0.
- Cur=19:00. Mode, inc (H1=2) → H0 forced to 3 (23:00). Next, inc → H0 wraps to 0. M1 inc ×6 from 0 → 0.
- Hold inc for 20 cycles on M0 (REPEAT_DELAY=10, REPEAT_RATE=3) → increments at cycles 1, 11, 14, 17, 20; M0=5.
- Mode and next rise in the same cycle in E_H0 → cancel to IDLE, no strobe. Reset asserted during COMMIT → no strobe, all outputs 0.
- Inc/next pulses in IDLE → no output change. Re-entry via mode reloads from the current time.
